// File: rtl/lfsr_sched_pkg.sv
// lfsr_sched_pkg: shared FSM state encoding and flattened-bus slicing helper for lfsr_burst_sched.
package lfsr_sched_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, STREAM, STEP, DONE} state_t;
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/lfsr_burst_sched_rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter; first requester at/after the pointer wins, pointer moves past it.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);
  logic [IW-1:0] ptr_q, ptr_d;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_q) + k) % NUM_REQ]) begin
        idx_o = IW'((int'(ptr_q) + k) % NUM_REQ);
        gnt_o = NUM_REQ'(1) << ((int'(ptr_q) + k) % NUM_REQ);
      end
    end
    ptr_d = (en_i && |req_i) ? ((idx_o == IW'(NUM_REQ - 1)) ? '0 : idx_o + IW'(1)) : ptr_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/lfsr_burst_sched.sv
// lfsr_burst_sched: round-robin scheduler sharing one Galois LFSR core, streaming LEN words per grant.
// Define LFSR_SCHED_ZERO_GUARD_EN to replace zero seeds and abort bursts when the core locks up at 0.
module lfsr_burst_sched
  import lfsr_sched_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 8
) (
  input  logic                       CLK_I,
  input  logic                       RST_I,
  input  logic [NUM_REQ-1:0]         REQ_I,
  input  logic [NUM_REQ*MAX_LEN-1:0] SEED_I,
  input  logic [NUM_REQ*MAX_LEN-1:0] POLY_I,
  input  logic [NUM_REQ*LEN_W-1:0]   LEN_I,
  output logic [NUM_REQ-1:0]         GNT_O,
  output logic [MAX_LEN-1:0]         DATA_O,
  output logic                       VALID_O,
  input  logic                       READY_I,
  output logic                       DONE_O,
  output logic                       ERR_O,
  output logic                       LFSR_LOAD_O,
  output logic                       LFSR_EN_O,
  output logic [MAX_LEN-1:0]         LFSR_SEED_O,
  output logic [MAX_LEN-1:0]         LFSR_POLY_O,
  input  logic [MAX_LEN-1:0]         LFSR_DATA_I
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] arb_gnt, gnt_q, gnt_d;
  logic [IW-1:0] arb_idx;
  logic [MAX_LEN-1:0] win_seed, seed_in, seed_q, seed_d, poly_q, poly_d, data_q, data_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic valid_q, valid_d, done_q, done_d, err_q, err_d, load_q, load_d;
  logic arb_sel, hs, last, zero_word;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i(CLK_I),
    .rst_i(RST_I),
    .en_i (state_q == IDLE),
    .req_i(REQ_I),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx)
  );
  assign win_seed = SEED_I[slice_lo(int'(arb_idx), MAX_LEN) +: MAX_LEN];
`ifdef LFSR_SCHED_ZERO_GUARD_EN
  assign seed_in   = (win_seed == '0) ? MAX_LEN'(1) : win_seed;
  assign zero_word = LFSR_DATA_I == '0;
`else
  assign seed_in   = win_seed;
  assign zero_word = 1'b0;
`endif
  assign arb_sel = (state_q == IDLE) && (|REQ_I);
  assign hs      = (state_q == STREAM) && READY_I;
  // Compare before increment so LEN = 2^LEN_W-1 never wraps the counter.
  assign last    = cnt_q == len_q - LEN_W'(1);
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      seed_q  <= '0;
      poly_q  <= '0;
      data_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      seed_q  <= seed_d;
      poly_q  <= poly_d;
      data_q  <= data_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         state_d = arb_sel ? LOAD : IDLE;
      LOAD:         state_d = (len_q == '0) ? DONE : SETTLE;
      SETTLE, STEP: state_d = zero_word ? DONE : STREAM;
      STREAM:       state_d = hs ? (last ? DONE : STEP) : STREAM;
      default:      state_d = IDLE;
    endcase
  end
  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    seed_d  = arb_sel ? seed_in : seed_q;
    poly_d  = arb_sel ? POLY_I[slice_lo(int'(arb_idx), MAX_LEN) +: MAX_LEN] : poly_q;
    len_d   = arb_sel ? LEN_I[slice_lo(int'(arb_idx), LEN_W) +: LEN_W] : len_q;
    cnt_d   = (state_q == IDLE) ? '0 : cnt_q + LEN_W'(hs);
    gnt_d   = (state_d == IDLE || state_d == DONE) ? '0 : arb_sel ? arb_gnt : gnt_q;
    load_d  = (state_d == LOAD) && (len_d != '0);
    valid_d = state_d == STREAM;
    data_d  = (state_d != STREAM) ? '0 : (state_q == STREAM) ? data_q : LFSR_DATA_I;
    done_d  = state_d == DONE;
    err_d   = err_q | ((state_q == SETTLE || state_q == STEP) && zero_word);
  end
  assign GNT_O       = gnt_q;
  assign DATA_O      = data_q;
  assign VALID_O     = valid_q;
  assign DONE_O      = done_q;
  assign ERR_O       = err_q;
  assign LFSR_LOAD_O = load_q;
  assign LFSR_SEED_O = seed_q;
  assign LFSR_POLY_O = poly_q;
  // The core must advance on the accepting cycle itself to sustain one word per two cycles.
  assign LFSR_EN_O   = hs && !last;
endmodule

// File: tb/tb_lfsr_burst_sched.sv
// tb_lfsr_burst_sched: randomized bench with an LFSR core stub and a burst-level reference model.
module tb_lfsr_burst_sched;
  localparam int W = 8, N = 4, LW = 8;
  logic clk = 1'b0, rst = 1'b0, ready = 1'b0, clr = 1'b0;
  logic [N-1:0] req = '0, gnt;
  logic [N*W-1:0] seed = '0, poly = '0;
  logic [N*LW-1:0] len = '0;
  logic [W-1:0] data, lseed, lpoly, core, load_seed;
  logic valid, done, err, lload, len_en;
  logic [N-1:0] gnt_prev;
  logic [W-1:0] words[$];
  int grants[$];
  int pass_cnt = 0, total = 0, mptr = 0;
  int cyc, dones, loads, gnt_cyc, gnt_t, vld_t, done_t;
  always #5 clk = ~clk;
  lfsr_burst_sched #(.MAX_LEN(W), .NUM_REQ(N), .LEN_W(LW)) dut (
    .CLK_I(clk), .RST_I(rst), .REQ_I(req), .SEED_I(seed), .POLY_I(poly), .LEN_I(len),
    .GNT_O(gnt), .DATA_O(data), .VALID_O(valid), .READY_I(ready), .DONE_O(done), .ERR_O(err),
    .LFSR_LOAD_O(lload), .LFSR_EN_O(len_en), .LFSR_SEED_O(lseed), .LFSR_POLY_O(lpoly),
    .LFSR_DATA_I(core)
  );
  function automatic logic [W-1:0] galois(input logic [W-1:0] s, input logic [W-1:0] p);
    return (s >> 1) ^ (s[0] ? p : '0);
  endfunction
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  always_ff @(posedge clk) core <= rst ? '0 : lload ? lseed : len_en ? galois(core, lpoly) : core;
  always @(negedge clk) begin
    if (clr) begin
      words.delete(); grants.delete();
      cyc = 0; dones = 0; loads = 0; gnt_cyc = 0; gnt_t = -1; vld_t = -1; done_t = -1;
      load_seed = 'x; gnt_prev = '0;
    end else begin
      cyc++;
      if (valid && ready) words.push_back(data);
      if (valid && vld_t < 0) vld_t = cyc;
      if (done) begin dones++; if (done_t < 0) done_t = cyc; end
      if (lload) begin loads++; load_seed = lseed; end
      if (gnt != '0) gnt_cyc++;
      if (gnt != '0 && gnt_prev == '0) begin
        if (gnt_t < 0) gnt_t = cyc;
        for (int i = 0; i < N; i++) if (gnt[i]) grants.push_back(i);
      end
      gnt_prev = gnt;
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic clr_mon();
    clr = 1'b1; @(negedge clk); #1; clr = 1'b0; tick();
  endtask
  task automatic do_reset();
    req = '0; ready = 1'b0; rst = 1'b1; tick(); tick(); rst = 1'b0; mptr = 0; clr_mon();
  endtask
  task automatic grab(input logic [N-1:0] r, input bit rnd);
    req = r;
    for (int c = 0; c < 20 && gnt == '0; c++) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      tick();
    end
    req = '0;
  endtask
  task automatic run(input int target, input int bound, input bit rnd);
    for (int c = 0; c < bound && dones < target; c++) begin
      if (rnd) ready = 1'($urandom_range(0, 1));
      tick();
    end
    ready = 1'b1;
    repeat (3) tick();
  endtask
  task automatic test_reset();
    rst = 1'b1; #2;
    total++; if ({gnt, data, valid, done, err, lload, len_en, lseed, lpoly} !== '0)
      $display("FAIL reset_outputs: got %0h expected 0", {gnt, data, valid, done, err, lload, len_en, lseed, lpoly}); else pass_cnt++;
    tick(); rst = 1'b0; tick(); tick();
    total++; if ({gnt, valid, done, lload, len_en} !== '0)
      $display("FAIL idle_quiet: got %0h expected 0", {gnt, valid, done, lload, len_en}); else pass_cnt++;
  endtask
  task automatic test_basic();
    logic [W-1:0] s, got;
    int w, g;
    do_reset();
    seed[0 +: W] = 8'h01; poly[0 +: W] = 8'hB8; len[0 +: LW] = 8'd3; ready = 1'b1;
    grab(4'b0001, 1'b0); run(1, 50, 1'b0);
    w = rr_pick(4'b0001, mptr); mptr = (w + 1) % N;
    g = grants.size() > 0 ? grants[0] : -1;
    total++; if (grants.size() != 1 || g != w) $display("FAIL basic_grant: got %0d (n=%0d) expected %0d", g, grants.size(), w); else pass_cnt++;
    total++; if (words.size() != 3) $display("FAIL basic_count: got %0d expected 3", words.size()); else pass_cnt++;
    s = 8'h01;
    for (int i = 0; i < 3; i++) begin
      got = i < words.size() ? words[i] : 'x;
      total++; if (got !== s) $display("FAIL basic_word%0d: got %0h expected %0h", i, got, s); else pass_cnt++;
      s = galois(s, 8'hB8);
    end
    total++; if (dones != 1) $display("FAIL basic_done_pulses: got %0d expected 1", dones); else pass_cnt++;
    total++; if (vld_t - gnt_t != 2) $display("FAIL basic_latency: got %0d expected 2", vld_t - gnt_t); else pass_cnt++;
    total++; if (loads != 1) $display("FAIL basic_loads: got %0d expected 1", loads); else pass_cnt++;
  endtask
  task automatic test_rr();
    int e, g;
    logic [W-1:0] got, es;
    do_reset(); ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      seed[i*W +: W] = W'($urandom_range(1, 255)); poly[i*W +: W] = W'($urandom) | 8'h80; len[i*LW +: LW] = 8'd1;
    end
    req = '1;
    for (int c = 0; c < 200 && grants.size() < 5; c++) tick();
    req = '0;
    for (int c = 0; c < 50 && dones < grants.size(); c++) tick();
    repeat (3) tick();
    total++; if (dones != grants.size()) $display("FAIL rr_dones: got %0d expected %0d", dones, grants.size()); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      e = rr_pick('1, mptr); mptr = (e + 1) % N;
      g = k < grants.size() ? grants[k] : -1;
      total++; if (g != e) $display("FAIL rr_grant%0d: got %0d expected %0d", k, g, e); else pass_cnt++;
      got = k < words.size() ? words[k] : 'x; es = seed[e*W +: W];
      total++; if (got !== es) $display("FAIL rr_word%0d: got %0h expected %0h", k, got, es); else pass_cnt++;
    end
  endtask
  task automatic test_random();
    logic [N-1:0] r;
    logic [W-1:0] s, p, got;
    int w, l, g;
    do_reset();
    for (int it = 0; it < 8; it++) begin
      r = N'($urandom_range(1, 2**N - 1));
      for (int i = 0; i < N; i++) begin
        seed[i*W +: W] = W'($urandom_range(1, 255)); poly[i*W +: W] = W'($urandom) | 8'h80;
        len[i*LW +: LW] = LW'($urandom_range(1, 5));
      end
      clr_mon();
      grab(r, 1'b1); run(1, 200, 1'b1);
      w = rr_pick(r, mptr); mptr = (w + 1) % N;
      g = grants.size() > 0 ? grants[0] : -1;
      total++; if (g != w) $display("FAIL rand%0d_grant: got %0d expected %0d", it, g, w); else pass_cnt++;
      l = int'(len[w*LW +: LW]); s = seed[w*W +: W]; p = poly[w*W +: W];
      total++; if (words.size() != l) $display("FAIL rand%0d_count: got %0d expected %0d", it, words.size(), l); else pass_cnt++;
      for (int j = 0; j < l; j++) begin
        got = j < words.size() ? words[j] : 'x;
        total++; if (got !== s) $display("FAIL rand%0d_word%0d: got %0h expected %0h", it, j, got, s); else pass_cnt++;
        s = galois(s, p);
      end
    end
  endtask
  task automatic test_stall();
    logic [W-1:0] got;
    do_reset();
    seed[0 +: W] = 8'h5A; poly[0 +: W] = 8'hB8; len[0 +: LW] = 8'd2;
    grab(4'b0001, 1'b0);
    for (int c = 0; c < 20 && !valid; c++) tick();
    for (int k = 0; k < 5; k++) begin
      total++; if ({valid, data, len_en} !== {1'b1, 8'h5A, 1'b0})
        $display("FAIL stall%0d: got v=%0b d=%0h en=%0b expected v=1 d=5a en=0", k, valid, data, len_en); else pass_cnt++;
      tick();
    end
    ready = 1'b1; run(1, 50, 1'b0);
    total++; if (words.size() != 2) $display("FAIL stall_count: got %0d expected 2", words.size()); else pass_cnt++;
    got = words.size() > 1 ? words[1] : 'x;
    total++; if (got !== galois(8'h5A, 8'hB8)) $display("FAIL stall_word1: got %0h expected %0h", got, galois(8'h5A, 8'hB8)); else pass_cnt++;
  endtask
  task automatic test_len0();
    int g;
    do_reset();
    seed[2*W +: W] = 8'h77; poly[2*W +: W] = 8'hB8; len[2*LW +: LW] = 8'd0; ready = 1'b1;
    grab(4'b0100, 1'b0); run(1, 20, 1'b0);
    g = grants.size() > 0 ? grants[0] : -1;
    total++; if (g != 2) $display("FAIL len0_grant: got %0d expected 2", g); else pass_cnt++;
    total++; if (loads != 0) $display("FAIL len0_loads: got %0d expected 0", loads); else pass_cnt++;
    total++; if (vld_t >= 0) $display("FAIL len0_valid: got valid at %0d expected never", vld_t); else pass_cnt++;
    total++; if (done_t - gnt_t != 1) $display("FAIL len0_done_delay: got %0d expected 1", done_t - gnt_t); else pass_cnt++;
    total++; if (gnt_cyc != 1 || dones != 1) $display("FAIL len0_pulses: got gnt=%0d done=%0d expected 1/1", gnt_cyc, dones); else pass_cnt++;
  endtask
  task automatic test_reset_mid();
    int g, e;
    logic [W-1:0] got;
    do_reset();
    seed[1*W +: W] = 8'h33; poly[1*W +: W] = 8'hB8; len[1*LW +: LW] = 8'd5;
    grab(4'b0010, 1'b0);
    for (int c = 0; c < 20 && !valid; c++) tick();
    rst = 1'b1; #1;
    total++; if ({gnt, data, valid, done, err, lload, len_en, lseed, lpoly} !== '0)
      $display("FAIL midreset_outputs: got %0h expected 0", {gnt, data, valid, done, err, lload, len_en, lseed, lpoly}); else pass_cnt++;
    tick(); rst = 1'b0; mptr = 0; clr_mon();
    len[1*LW +: LW] = 8'd1; seed[3*W +: W] = 8'h44; poly[3*W +: W] = 8'hB8; len[3*LW +: LW] = 8'd1; ready = 1'b1;
    grab(4'b1010, 1'b0); run(1, 30, 1'b0);
    e = rr_pick(4'b1010, mptr);
    g = grants.size() > 0 ? grants[0] : -1;
    total++; if (g != e) $display("FAIL midreset_restart: got %0d expected %0d", g, e); else pass_cnt++;
    got = words.size() > 0 ? words[0] : 'x;
    total++; if (got !== 8'h33) $display("FAIL midreset_word: got %0h expected 33", got); else pass_cnt++;
  endtask
  task automatic test_zero_seed();
    logic [W-1:0] e0, e1, g0, g1;
`ifdef LFSR_SCHED_ZERO_GUARD_EN
    e0 = 8'h01; e1 = 8'hB8;
`else
    e0 = 8'h00; e1 = 8'h00;
`endif
    do_reset();
    seed[0 +: W] = 8'h00; poly[0 +: W] = 8'hB8; len[0 +: LW] = 8'd2; ready = 1'b1;
    grab(4'b0001, 1'b0); run(1, 30, 1'b0);
    total++; if (load_seed !== e0) $display("FAIL zero_load_seed: got %0h expected %0h", load_seed, e0); else pass_cnt++;
    g0 = words.size() > 0 ? words[0] : 'x; g1 = words.size() > 1 ? words[1] : 'x;
    total++; if ({g0, g1} !== {e0, e1}) $display("FAIL zero_words: got %0h %0h expected %0h %0h", g0, g1, e0, e1); else pass_cnt++;
    total++; if (err !== 1'b0) $display("FAIL zero_err: got %0b expected 0", err); else pass_cnt++;
  endtask
  task automatic test_maxlen();
    logic [W-1:0] s, got;
    do_reset();
    s = W'($urandom_range(1, 255));
    seed[0 +: W] = s; poly[0 +: W] = 8'hB8; len[0 +: LW] = 8'hFF; ready = 1'b1;
    grab(4'b0001, 1'b0); run(1, 700, 1'b0);
    for (int i = 0; i < 254; i++) s = galois(s, 8'hB8);
    total++; if (words.size() != 255) $display("FAIL maxlen_count: got %0d expected 255", words.size()); else pass_cnt++;
    got = words.size() == 255 ? words[254] : 'x;
    total++; if (got !== s) $display("FAIL maxlen_last: got %0h expected %0h", got, s); else pass_cnt++;
    total++; if (dones != 1) $display("FAIL maxlen_done: got %0d expected 1", dones); else pass_cnt++;
  endtask
  initial begin
    tick();
    test_reset();
    test_basic();
    test_rr();
    test_random();
    test_stall();
    test_len0();
    test_reset_mid();
    test_zero_seed();
    test_maxlen();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
